// File: rtl/uart_header_assembler.sv
// ============================================================================
//  Module      : uart_header_assembler
//  Description : Collects bytes from the uart receiver handshake (data/ready/
//                clear) into a fixed-length block header. The first byte
//                received becomes the most significant byte. A partial frame
//                that goes idle for too long is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_header_assembler #(
  parameter int HEADER_BYTES   = 80,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_ready,
  output logic                      rx_clear,
  output logic [8*HEADER_BYTES-1:0] header_data,
  output logic                      header_valid,
  output logic                      frame_error,
  output logic [6:0]                byte_count
);

  localparam int c_hw = 8 * HEADER_BYTES;
  localparam int c_tw = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [c_tw-1:0] c_to_last   = c_tw'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]      c_last_byte = 7'(HEADER_BYTES - 1);

  // IDLE: no partial frame, RECV: partial frame with timeout running,
  // ACK: holding rx_clear until the receiver drops ready, DONE: header published.
  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_recv = 2'd1;
  localparam logic [1:0] c_ack  = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  logic [1:0]      r_state;
  logic [c_hw-1:0] r_buffer;
  logic [c_tw-1:0] r_timer;
  logic            r_frame_full;

  logic            w_capture;
  logic            w_expire;
  logic            w_release;
  logic            w_publish;

  // A byte is taken only while waiting for data; ACK blocks re-capture of a
  // ready level that the receiver has not yet lowered.
  assign w_capture = ((r_state == c_idle) || (r_state == c_recv)) && rx_ready;
  // A capture in the expiry cycle wins, so expiry requires ready low.
  assign w_expire  = (r_state == c_recv) && !rx_ready && (r_timer == c_to_last);
  assign w_release = (r_state == c_ack) && !rx_ready;
  assign w_publish = w_release && r_frame_full;

  // Frame state sequencing and the rx_clear acknowledge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= c_idle;
      rx_clear <= 1'b0;
    end else begin
      case (r_state)
        c_idle, c_recv: begin
          if (w_capture) begin
            r_state  <= c_ack;
            rx_clear <= 1'b1;
          end else if (w_expire) begin
            r_state  <= c_idle;
          end
        end
        c_ack: begin
          if (w_release) begin
            rx_clear <= 1'b0;
            r_state  <= r_frame_full ? c_done : c_recv;
          end
        end
        c_done: begin
          // Ready is not looked at here; a waiting byte is taken from IDLE.
          r_state <= c_idle;
        end
        default: begin
          r_state  <= c_idle;
          rx_clear <= 1'b0;
        end
      endcase
    end
  end

  // Byte counter, wrapping on the final byte with a flag marking the frame full
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_count   <= 7'd0;
      r_frame_full <= 1'b0;
    end else if (w_capture) begin
      if (byte_count == c_last_byte) begin
        byte_count   <= 7'd0;
        r_frame_full <= 1'b1;
      end else begin
        byte_count   <= byte_count + 7'd1;
      end
    end else if (w_expire) begin
      byte_count   <= 7'd0;
    end else if (w_publish) begin
      r_frame_full <= 1'b0;
    end
  end

  // Shift buffer: new bytes enter at the LSB so the first byte ends up on top
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buffer <= '0;
    end else if (w_capture) begin
      r_buffer <= {r_buffer[c_hw-9:0], rx_data};
    end else if (w_expire || w_publish) begin
      r_buffer <= '0;
    end
  end

  // Inter-byte idle timer, only advancing while a partial frame waits for data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_capture || w_expire) begin
      r_timer <= '0;
    end else if (r_state == c_recv) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Published header and the one-cycle status pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      header_data  <= '0;
      header_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      header_valid <= w_publish;
      frame_error  <= w_expire;
      if (w_publish) begin
        header_data <= r_buffer;
      end
    end
  end

endmodule

`default_nettype wire
